// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of a single register-file write port.
// Round-robin or fixed-priority grant; the winning write is registered for one cycle.
module regfile_wb_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_stall,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_reg,
    input  logic [31:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_reg,
    input  logic [31:0] i_b_data,
    output logic        o_b_ready,
    output logic        RegWrite,
    output logic [4:0]  o_writeReg,
    output logic [31:0] o_data,
    output logic        o_last_b
);

    logic        grant_a;
    logic        grant_b;
    logic        grant_any;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    // On a tie, A wins in fixed-priority mode or when B held the previous grant.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!i_arst && !i_stall) begin
            if (i_a_valid && i_b_valid) begin
                if (PRIO_MODE == 1 || o_last_b) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (i_a_valid) begin
                grant_a = 1'b1;
            end else if (i_b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        sel_reg  = i_a_reg;
        sel_data = i_a_data;
        if (grant_b) begin
            sel_reg  = i_b_reg;
            sel_data = i_b_data;
        end
    end

    assign grant_any = grant_a | grant_b;
    assign o_a_ready = grant_a;
    assign o_b_ready = grant_b;

    // Writes to register 0 are accepted but suppressed, with index and data cleared.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            RegWrite   <= 1'b0;
            o_writeReg <= '0;
            o_data     <= '0;
            o_last_b   <= 1'b1;
        end else begin
            RegWrite <= 1'b0;
            if (grant_any) begin
                o_last_b <= grant_b;
                if (sel_reg == 5'd0) begin
                    o_writeReg <= '0;
                    o_data     <= '0;
                end else begin
                    RegWrite   <= 1'b1;
                    o_writeReg <= sel_reg;
                    o_data     <= sel_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a round-robin and a fixed-priority
// instance are exercised in turn with directed and random writeback traffic.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
        logic        lb;
    } wb_t;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst, stall, av, bv;
    logic [1:0][4:0]   ar, br;
    logic [1:0][31:0]  ad, bd;
    logic [1:0]        a_rdy, b_rdy, we, lb;
    logic [1:0][4:0]   wr;
    logic [1:0][31:0]  wd;

    int n_checks = 0;
    int n_errors = 0;

    wb_t sb0[$];
    wb_t sb1[$];

    logic [1:0]       mdl_lb;
    logic [1:0][4:0]  mdl_r;
    logic [1:0][31:0] mdl_d;

    regfile_wb_arbiter #(.PRIO_MODE(0)) u_rr (
        .i_clk(clk), .i_arst(rst[0]), .i_stall(stall[0]),
        .i_a_valid(av[0]), .i_a_reg(ar[0]), .i_a_data(ad[0]), .o_a_ready(a_rdy[0]),
        .i_b_valid(bv[0]), .i_b_reg(br[0]), .i_b_data(bd[0]), .o_b_ready(b_rdy[0]),
        .RegWrite(we[0]), .o_writeReg(wr[0]), .o_data(wd[0]), .o_last_b(lb[0])
    );

    regfile_wb_arbiter #(.PRIO_MODE(1)) u_fp (
        .i_clk(clk), .i_arst(rst[1]), .i_stall(stall[1]),
        .i_a_valid(av[1]), .i_a_reg(ar[1]), .i_a_data(ad[1]), .o_a_ready(a_rdy[1]),
        .i_b_valid(bv[1]), .i_b_reg(br[1]), .i_b_data(bd[1]), .o_b_ready(b_rdy[1]),
        .RegWrite(we[1]), .o_writeReg(wr[1]), .o_data(wd[1]), .o_last_b(lb[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance m: inputs are already driven. Returns observed readys.
    task automatic cycle(input int m, output logic oa, output logic ob);
        logic  ea, eb;
        wb_t   e, got;
        #4;
        ea = 1'b0;
        eb = 1'b0;
        if (!rst[m] && !stall[m]) begin
            if (av[m] && bv[m]) begin
                if (m == 1 || mdl_lb[m]) ea = 1'b1;
                else                     eb = 1'b1;
            end else if (av[m]) begin
                ea = 1'b1;
            end else if (bv[m]) begin
                eb = 1'b1;
            end
        end
        oa = a_rdy[m];
        ob = b_rdy[m];
        check("a_ready", oa, ea);
        check("b_ready", ob, eb);
        e.we = 1'b0;
        if (rst[m]) begin
            mdl_lb[m] = 1'b1;
            mdl_r[m]  = '0;
            mdl_d[m]  = '0;
        end else if (ea || eb) begin
            mdl_lb[m] = eb;
            if ((ea ? ar[m] : br[m]) == 5'd0) begin
                mdl_r[m] = '0;
                mdl_d[m] = '0;
            end else begin
                e.we     = 1'b1;
                mdl_r[m] = ea ? ar[m] : br[m];
                mdl_d[m] = ea ? ad[m] : bd[m];
            end
        end
        e.r  = mdl_r[m];
        e.d  = mdl_d[m];
        e.lb = mdl_lb[m];
        if (m == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(posedge clk);
        #1;
        if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = (m == 0) ? sb0.pop_front() : sb1.pop_front();
            check("RegWrite", we[m], got.we);
            check("writeReg", wr[m], got.r);
            check("data", wd[m], got.d);
            check("last_b", lb[m], got.lb);
        end
    endtask

    task automatic rand_run(input int m, input int n);
        logic oa, ob;
        oa = 1'b0;
        ob = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!av[m] || oa) begin
                av[m] = ($urandom % 3) != 0;
                ar[m] = 5'($urandom);
                ad[m] = $urandom;
            end
            if (!bv[m] || ob) begin
                bv[m] = ($urandom % 3) != 0;
                br[m] = 5'($urandom);
                bd[m] = $urandom;
            end
            stall[m] = ($urandom % 6) == 0;
            cycle(m, oa, ob);
        end
        stall[m] = 1'b0;
        av[m]    = 1'b0;
        bv[m]    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       oa, ob;
        logic [3:0] order;
        rst = 2'b11; stall = '0; av = '0; bv = '0;
        ar = '0; br = '0; ad = '0; bd = '0;
        mdl_lb = 2'b11; mdl_r = '0; mdl_d = '0;
        @(posedge clk);
        #1;

        // Round-robin instance: reset with both requests pending.
        av[0] = 1'b1; ar[0] = 5'd3; ad[0] = 32'hA000_0003;
        bv[0] = 1'b1; br[0] = 5'd4; bd[0] = 32'hB000_0004;
        cycle(0, oa, ob);
        cycle(0, oa, ob);
        check("rst_regwrite", we[0], 0);
        rst[0] = 1'b0;
        cycle(0, oa, ob);
        check("post_rst_first_a", oa, 1);
        av[0] = 1'b0;
        cycle(0, oa, ob);
        check("post_rst_then_b", ob, 1);
        bv[0] = 1'b0;

        // Single A request.
        av[0] = 1'b1; ar[0] = 5'd5; ad[0] = 32'h1234_5678;
        cycle(0, oa, ob);
        check("single_a_ready", oa, 1);
        check("single_a_reg", wr[0], 5);
        check("single_a_data", wd[0], 32'h1234_5678);
        av[0] = 1'b0;

        // B writes register 0: accepted, no write, outputs cleared.
        bv[0] = 1'b1; br[0] = 5'd0; bd[0] = 32'hFFFF_FFFF;
        cycle(0, oa, ob);
        check("r0_ready", ob, 1);
        check("r0_regwrite", we[0], 0);
        check("r0_data", wd[0], 0);
        bv[0] = 1'b0;

        // Continuous contention: strict alternation starting with A.
        av[0] = 1'b1; ar[0] = 5'd10; ad[0] = 32'hA10;
        bv[0] = 1'b1; br[0] = 5'd20; bd[0] = 32'hB20;
        order = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, oa, ob);
            order = {order[2:0], ob};
            check("alt_regwrite", we[0], 1);
            if (oa) begin ar[0] = ar[0] + 5'd1; ad[0] = ad[0] + 32'd1; end
            if (ob) begin br[0] = br[0] + 5'd1; bd[0] = bd[0] + 32'd1; end
        end
        check("rr_order", order, 4'b0101);

        // Stall with both pending, then resume from the pre-stall pointer.
        stall[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(0, oa, ob);
            check("stall_regwrite", we[0], 0);
        end
        stall[0] = 1'b0;
        cycle(0, oa, ob);
        check("post_stall_a", oa, 1);

        // Both target the same register.
        ar[0] = 5'd7; ad[0] = 32'h0000_AAAA;
        br[0] = 5'd7; bd[0] = 32'h0000_BBBB;
        for (int i = 0; i < 2; i++) begin
            cycle(0, oa, ob);
            if (oa) av[0] = 1'b0;
            if (ob) bv[0] = 1'b0;
        end
        check("same_reg_last", wd[0], 32'h0000_AAAA);
        cycle(0, oa, ob);
        check("idle_hold_reg", wr[0], 7);
        rand_run(0, 300);

        // Fixed-priority instance.
        cycle(1, oa, ob);
        rst[1] = 1'b0;
        av[1] = 1'b1; ar[1] = 5'd1; ad[1] = 32'hA1;
        bv[1] = 1'b1; br[1] = 5'd9; bd[1] = 32'hB9;
        order = '0;
        for (int i = 0; i < 3; i++) begin
            cycle(1, oa, ob);
            order = {order[2:0], oa};
            if (oa) begin ar[1] = ar[1] + 5'd1; ad[1] = ad[1] + 32'd1; end
        end
        check("prio_a_thrice", order, 4'b0111);
        av[1] = 1'b0;
        cycle(1, oa, ob);
        check("prio_b_grant", ob, 1);
        check("prio_b_reg", wr[1], 9);
        check("prio_b_data", wd[1], 32'hB9);
        bv[1] = 1'b0;
        rand_run(1, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
